// File: rtl/baud_pkg.sv
// Shared register addresses, default geometry and helpers for the baud divisor generator.
package baud_pkg;

  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  localparam int unsigned DEF_DIV_W       = 16;
  localparam int unsigned DEF_OVERSAMPLE  = 16;
  localparam int unsigned DEF_DEFAULT_DIV = 326;

  function automatic int unsigned nbytes(input int unsigned div_w);
    return div_w / 8;
  endfunction

endpackage

// File: rtl/baud_tick_counter.sv
// Oversample tick down-counter and bit-tick divider; load restarts the phase from div.
module baud_tick_counter
  import baud_pkg::*;
#(
  parameter int unsigned DIV_W       = DEF_DIV_W,
  parameter int unsigned OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int unsigned DEFAULT_DIV = DEF_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  input  logic             en,
  output logic             tick,
  output logic             bit_tick
);

  localparam int unsigned OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  logic [DIV_W-1:0] cnt;
  logic [OS_W-1:0]  os_cnt;
  logic             expire_c;
  logic             wrap_c;

  assign expire_c = en && (cnt == '0);
  assign wrap_c   = (os_cnt == OS_W'(OVERSAMPLE - 1));

  // The expiring period's tick is still issued when a load lands on cnt==0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= DIV_W'(DEFAULT_DIV - 1);
      os_cnt   <= '0;
      tick     <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      tick     <= expire_c;
      bit_tick <= expire_c && wrap_c;
      if (load) begin
        cnt    <= (div == '0) ? '0 : div - DIV_W'(1);
        os_cnt <= '0;
      end else if (!en) begin
        cnt <= '0;
      end else if (expire_c) begin
        cnt    <= div - DIV_W'(1);
        os_cnt <= wrap_c ? '0 : os_cnt + OS_W'(1);
      end else begin
        cnt <= cnt - DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/baud_div_gen.sv
// Byte-wise baud divisor assembly with atomic commit, driving the tick generator.
// Optional BAUD_PENDING_FLAG_EN adds pending and sticky seq_err status outputs.
module baud_div_gen
  import baud_pkg::*;
#(
  parameter int unsigned DIV_W       = DEF_DIV_W,
  parameter int unsigned DEFAULT_DIV = DEF_DEFAULT_DIV,
  parameter int unsigned OVERSAMPLE  = DEF_OVERSAMPLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       io_addr,
  input  logic             baud_write,
  input  logic [7:0]       data_in,
  output logic [DIV_W-1:0] div_active,
  output logic             div_rdy,
  output logic             tick,
  output logic             bit_tick
`ifdef BAUD_PENDING_FLAG_EN
  ,
  output logic             pending,
  output logic             seq_err
`endif
);

  localparam int unsigned NBYTES = nbytes(DIV_W);
  localparam int unsigned PTR_W  = $clog2(NBYTES + 1);

  logic [DIV_W-1:0] shadow;
  logic [DIV_W-1:0] asm_c;
  logic [DIV_W-1:0] div_sel_c;
  logic [PTR_W-1:0] ptr;
  logic             lo_wr_c;
  logic             hi_wr_c;
  logic             hi_ok_c;
  logic             commit_c;

  assign lo_wr_c  = baud_write && (io_addr == ADDR_DIV_LO);
  assign hi_wr_c  = baud_write && (io_addr == ADDR_DIV_HI);
  assign hi_ok_c  = hi_wr_c && (ptr < PTR_W'(NBYTES));
  assign commit_c = (hi_ok_c && (ptr == PTR_W'(NBYTES - 1))) || (lo_wr_c && (NBYTES == 1));

  // Shadow with the byte being written merged in; this is what a commit loads.
  always_comb begin
    asm_c = shadow;
    if (lo_wr_c) begin
      asm_c[7:0] = data_in;
    end else if (hi_ok_c) begin
      for (int unsigned b = 1; b < NBYTES; b++) begin
        if (ptr == PTR_W'(b)) asm_c[b*8 +: 8] = data_in;
      end
    end
  end

  assign div_sel_c = commit_c ? asm_c : div_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      div_active <= DIV_W'(DEFAULT_DIV);
      ptr        <= PTR_W'(1);
      div_rdy    <= 1'b0;
    end else begin
      div_rdy <= commit_c;
      if (lo_wr_c || hi_ok_c) shadow <= asm_c;
      if (commit_c) begin
        div_active <= asm_c;
        ptr        <= PTR_W'(1);
      end else if (lo_wr_c) begin
        ptr <= PTR_W'(1);
      end else if (hi_ok_c) begin
        ptr <= ptr + PTR_W'(1);
      end
    end
  end

`ifdef BAUD_PENDING_FLAG_EN
  logic lo_seen;

  // lo_seen tracks a low-byte write since the last commit, for sequence checking.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      seq_err <= 1'b0;
      lo_seen <= 1'b0;
    end else begin
      if (commit_c) begin
        pending <= 1'b0;
        lo_seen <= 1'b0;
      end else begin
        if (lo_wr_c || hi_ok_c) pending <= 1'b1;
        if (lo_wr_c) lo_seen <= 1'b1;
      end
      if (hi_wr_c && (ptr == PTR_W'(1)) && !lo_seen) seq_err <= 1'b1;
    end
  end
`endif

  baud_tick_counter #(
    .DIV_W      (DIV_W),
    .OVERSAMPLE (OVERSAMPLE),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) u_tick_counter (
    .clk     (clk),
    .rst     (rst),
    .div     (div_sel_c),
    .load    (commit_c),
    .en      (div_active != '0),
    .tick    (tick),
    .bit_tick(bit_tick)
  );

endmodule

// File: doc/baud_div_gen.md
Name: baud_div_gen

Overview:
Parametrised successor to the UART divisor buffer. Collects a DIV_W-bit baud divisor from byte-wide bus writes into a shadow register. Commits the full value atomically to an active register. Generates the oversample tick and the bit tick consumed by the UART TX/RX engines. Sits between the bus decode logic and the serial TX/RX datapaths.

Parameters:
DIV_W, 16, divisor width in bits; multiple of 8, range 8..32; NBYTES = DIV_W/8
DEFAULT_DIV, 16'd326, active divisor loaded at reset; must be nonzero and fit DIV_W
OVERSAMPLE, 16, ticks per bit_tick; range 2..64

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
io_addr  input  2  bus register address
baud_write  input  1  write strobe, one cycle per byte
data_in  input  8  write data byte
div_active  output  DIV_W  currently committed divisor
div_rdy  output  1  one-cycle pulse, cycle after commit
tick  output  1  one-cycle oversample enable
bit_tick  output  1  one-cycle pulse every OVERSAMPLE ticks

Behaviour:
- Reset, synchronous and active-high (rst=1 at a rising edge):
  - shadow=0, div_active=DEFAULT_DIV, cnt=DEFAULT_DIV-1, ptr=1, os_cnt=0
  - div_rdy=0, tick=0, bit_tick=0
  - Reset overrides any concurrent write; an in-progress byte sequence is discarded.
- Write decode; only when baud_write=1:
  - io_addr=2'b10: shadow[7:0] <= data_in; ptr <= 1. Restarts any partial sequence.
  - io_addr=2'b11: shadow byte[ptr] <= data_in; ptr <= ptr+1. When ptr==NBYTES-1, this is the commit write.
  - io_addr=2'b00/01: ignored, no state change.
  - With NBYTES=1, a 2'b10 write is itself the commit write.
- Commit, on the commit-write edge:
  - div_active <= assembled value, shadow plus the byte just written
  - ptr <= 1; counter and os_cnt reload (see below)
  - div_rdy=1 for exactly the next cycle. Latency: write cycle + 1.
- Write to 2'b11 without a preceding 2'b10 writes at the current ptr (1 after reset or commit). This gives DIV_W=16 compatibility with the old lo/hi sequence.
- Tick counter (down-counter cnt, DIV_W bits):
  - If div_active==0: halted; tick and bit_tick held 0; cnt held 0.
  - Else, if cnt==0: tick=1 (registered, visible the following cycle) and cnt <= div_active-1.
  - Else: cnt <= cnt-1.
  - Period = div_active cycles; div_active=1 gives tick every cycle.
- Bit counter:
  - On each tick, os_cnt <= (os_cnt==OVERSAMPLE-1) ? 0 : os_cnt+1.
  - bit_tick asserted coincident with the tick at which os_cnt wraps.
- Commit coincident with cnt==0:
  - tick for the expiring old period is still issued.
  - cnt reloads from the new divisor minus 1; os_cnt <= 0.
- Commit otherwise: cnt <= new divisor minus 1, os_cnt <= 0, so the phase restarts immediately.
- Writing the same value still commits and restarts the phase.
- No arithmetic overflow: cnt never loaded above div_active-1.

Optional Feature:
BAUD_PENDING_FLAG_EN
- Defined: adds output pending (1 bit). Set on any write that leaves ptr>=1 without committing. Cleared on commit and on reset. Also adds output seq_err (1 bit, sticky), set when a 2'b11 write arrives with ptr==1 and no 2'b10 since the last commit. Cleared on reset.
- Undefined: neither port exists; behaviour otherwise identical.

Decomposition:
- Package baud_pkg:
  - ADDR_DIV_LO=2'b10, ADDR_DIV_HI=2'b11
  - function nbytes(DIV_W)
  - default DIV_W/OVERSAMPLE constants
- Natural sub-module: baud_tick_counter. Contains the cnt/os_cnt logic, with inputs div, load, en and outputs tick, bit_tick.
- Byte assembly and commit stay in the top module.

Test Plan:
- Reset with DIV_W=16, DEFAULT_DIV=326 -> div_active=326, div_rdy=0; first tick 326 cycles after reset release, then every 326 cycles.
- Write 2'b10=0x04, then 2'b11=0x00 -> div_active=0x0004; div_rdy pulses 1 cycle after the second write; tick every 4 cycles; bit_tick every 64 cycles (OVERSAMPLE=16).
- DIV_W=24: write 10=0x01, 11=0x02, 11=0x03 -> div_active=0x030201. Commit only on the third write; div_rdy never asserts after the second.
- Write 10=0x00, 11=0x00 -> div_active=0; tick and bit_tick stay 0 for 1000 cycles. Then write 10=0x01, 11=0x00 -> tick asserted every cycle.
- Assert rst between the lo and hi writes, then write 11=0x05 -> shadow cleared, commit with div_active=0x0500; no stale lo byte.
- Commit timed on the cnt==0 cycle -> old tick still seen; next tick exactly new-divisor cycles later; os_cnt restarts at 0.
